// File: rtl/bloom_filter_csr.sv
// Avalon-MM CSR block for the bloom filter: enable, LUT clean sequencer, match counters, geometry info.
// Optional macro BLOOM_FILTER_CSR_CNT_SAT_EN makes the match counters saturate instead of wrapping.
module bloom_filter_csr #(
  parameter int MIN_STR_SIZE = 4,
  parameter int MAX_STR_SIZE = 20,
  parameter int LANES        = 8,
  parameter int CNT_W        = 32,
  parameter int CLEAN_ADDR_W = 18,
  parameter int CSR_ADDR_W   = 32,
  parameter int CSR_DATA_W   = 32,
  localparam int N_CNT       = (MAX_STR_SIZE - MIN_STR_SIZE + 1) * LANES
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CSR_ADDR_W-1:0]   amm_csr_address_i,
  input  logic                    amm_csr_read_i,
  input  logic                    amm_csr_write_i,
  input  logic [CSR_DATA_W-1:0]   amm_csr_writedata_i,
  output logic [CSR_DATA_W-1:0]   amm_csr_readdata_o,
  output logic                    amm_csr_readdatavalid_o,
  input  logic [N_CNT-1:0]        match_i,
  output logic                    en_o,
  output logic [CLEAN_ADDR_W-1:0] lut_clean_addr_o,
  output logic                    lut_clean_wr_o,
  output logic                    lut_clean_busy_o
);

  localparam int ADDR_EN    = 0;
  localparam int ADDR_CLEAN = 1;
  localparam int ADDR_CLEAR = N_CNT + 2;
  localparam int ADDR_INFO  = N_CNT + 3;

  localparam logic [31:0] INFO_VAL = {2'b00, 6'(CNT_W), 3'b000, 5'(LANES),
                                      3'b000, 5'(MAX_STR_SIZE), 3'b000, 5'(MIN_STR_SIZE)};

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state_q, state_d;
  logic [CLEAN_ADDR_W-1:0] addr_q, addr_d;
  logic                    en_q;
  logic [CNT_W-1:0]        cnt_q [N_CNT];
  logic [CSR_DATA_W-1:0]   rd_mux;
  logic                    wr_en_hit, wr_clean_start, wr_clear;
  logic                    unused_wdata;

  assign unused_wdata   = ^amm_csr_writedata_i[CSR_DATA_W-1:1];
  assign wr_en_hit      = amm_csr_write_i && (amm_csr_address_i == CSR_ADDR_W'(ADDR_EN));
  assign wr_clean_start = amm_csr_write_i && (amm_csr_address_i == CSR_ADDR_W'(ADDR_CLEAN))
                          && amm_csr_writedata_i[0];
  assign wr_clear       = amm_csr_write_i && (amm_csr_address_i == CSR_ADDR_W'(ADDR_CLEAR))
                          && amm_csr_writedata_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    lut_clean_wr_o   = 1'b0;
    lut_clean_busy_o = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (wr_clean_start) state_d = SWEEP;
      end
      SWEEP: begin
        lut_clean_wr_o   = 1'b1;
        lut_clean_busy_o = 1'b1;
        addr_d           = addr_q + 1'b1;
        if (addr_q == '1) begin
          state_d = IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lut_clean_addr_o = addr_q;
  assign en_o             = en_q & ~lut_clean_busy_o;

  always_ff @(posedge clk_i) begin
    if (rst_i)          en_q <= 1'b0;
    else if (wr_en_hit) en_q <= amm_csr_writedata_i[0];
  end

  // Clear takes priority over any increment landing on the same edge.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_CNT; i++) begin
      if (rst_i || wr_clear) begin
        cnt_q[i] <= '0;
      end else if (match_i[i] && en_o) begin
`ifdef BLOOM_FILTER_CSR_CNT_SAT_EN
        if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
`else
        cnt_q[i] <= cnt_q[i] + 1'b1;
`endif
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (amm_csr_address_i == CSR_ADDR_W'(ADDR_EN))    rd_mux[0] = en_q;
    if (amm_csr_address_i == CSR_ADDR_W'(ADDR_CLEAN)) rd_mux[0] = lut_clean_busy_o;
    for (int i = 0; i < N_CNT; i++) begin
      if (amm_csr_address_i == CSR_ADDR_W'(i + 2)) rd_mux = CSR_DATA_W'(cnt_q[i]);
    end
    if (amm_csr_address_i == CSR_ADDR_W'(ADDR_INFO))  rd_mux = CSR_DATA_W'(INFO_VAL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      amm_csr_readdatavalid_o <= 1'b0;
      amm_csr_readdata_o      <= '0;
    end else begin
      amm_csr_readdatavalid_o <= amm_csr_read_i;
      amm_csr_readdata_o      <= amm_csr_read_i ? rd_mux : '0;
    end
  end

endmodule
